multi_mode_shift_reg: RTL and testbench
=======================================

MULTI_MODE_SHIFT_REG -- requirements
Module: multi_mode_shift_reg

Interface
REQ-001 Parameter N, default 8: register width in bits; N SHALL be at least 2.
REQ-002 Parameter AMT_W, default 3: width of the shift-amount input.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port start, input, 1: request an operation; sampled on every rising clk edge.
REQ-006 Port mode, input, 3: operation select, sampled with start.
- 000 NOP
- 001 LOAD
- 010 SLL (shift left logical)
- 011 SRL (shift right logical)
- 100 ROL (rotate left)
- 101 ROR (rotate right)
- 110 SRA (shift right arithmetic)
- 111 SLA (shift left arithmetic)
REQ-007 Port amt, input, AMT_W: shift/rotate distance in bit positions, sampled with start.
REQ-008 Port d, input, N: parallel load data.
REQ-009 Port sin, input, 1: serial fill bit for SLL/SRL; sampled at every shift edge.
REQ-010 Port q, output, N: register contents; driven directly from the register.
REQ-011 Port sout, output, 1: registered copy of the bit that left the register at the most recent shift edge.
REQ-012 Port busy, output, 1: registered; high while a multi-cycle operation is in progress.
REQ-013 Port done, output, 1: registered; single-cycle completion pulse.

Function
REQ-014 The FSM SHALL have two states:
- IDLE: no operation in progress.
- SHIFT: multi-cycle operation in progress.
- A down-counter cnt of width AMT_W holds the remaining shift steps.
REQ-015 Accept rule: start is accepted only at an edge where the state is IDLE; start sampled in SHIFT SHALL be ignored, with no effect on q, cnt or the latched mode.
REQ-016 NOP accepted: q is unchanged and done = 1 for the following cycle.
REQ-017 LOAD accepted: q <= d at the accept edge; done = 1 for the following cycle; sout is unchanged.
REQ-018 Shift mode accepted with amt = 0: q is unchanged and done = 1 for the following cycle.
REQ-019 Shift mode accepted with amt = k >= 1, at the accept edge:
- Perform the first one-bit step.
- Latch the mode.
- Set cnt <= k-1.
- If k = 1: remain IDLE, done <= 1.
- Otherwise: enter SHIFT, busy <= 1.
REQ-020 At each edge in SHIFT:
- Perform one one-bit step using the latched mode.
- Decrement cnt.
- The edge at which cnt = 1 performs the final step, returns to IDLE, and sets busy <= 0, done <= 1.
REQ-021 Latency: q holds the final result after k edges counted from the accept edge inclusive; done is high in the cycle that follows; busy is high for exactly k-1 cycles.
REQ-022 One-bit step definitions:
- SLL: q <= {q[N-2:0], sin}
- SRL: q <= {sin, q[N-1:1]}
- ROL: q <= {q[N-2:0], q[N-1]}
- ROR: q <= {q[0], q[N-1:1]}
- SRA: q <= {q[N-1], q[N-1:1]}
- SLA: q <= {q[N-2:0], 1'b0}
REQ-023 At every shift step, sout SHALL take the bit that left the register: q[N-1] for SLL/ROL/SLA; q[0] for SRL/ROR/SRA. For rotates this equals the bit that wrapped around.
REQ-024 Distances of N or more positions SHALL be honoured step by step; there is no modulo reduction. For example, ROL by N returns the original value.
REQ-025 done SHALL be high for exactly one cycle per accepted operation and is never high while busy is high.
REQ-026 A new start is accepted at the same edge at which done is high, since the state is IDLE in that cycle; such back-to-back operations SHALL be supported.

Reset
REQ-027 At a rising edge with rst = 1 the block SHALL set:
- q = 0, sout = 0, busy = 0, done = 0, cnt = 0
- state = IDLE
REQ-028 rst SHALL take priority over start and over any in-progress SHIFT; a partially shifted value is discarded and no done pulse is produced.

Verification (N=8, AMT_W=3)
REQ-029 LOAD then ROL: LOAD d=8'hA5, then ROL amt=3 -> q=8'h2D three edges after accept; busy high 2 cycles; done pulse once; sout=1.
REQ-030 SRA: LOAD 8'h90, SRA amt=2 -> q=8'hE4; sout=0; SLA amt=1 on 8'h81 -> q=8'h02, sout=1.
REQ-031 Serial fill: LOAD 8'h0F, SLL amt=4 with sin=1 held -> q=8'hFF; then SRL amt=7 with sin=0 -> q=8'h01.
REQ-032 Ignored start and zero distance: assert start with mode=LOAD d=8'h3C during ROR amt=5 -> ignored, final q equals original ROR 5 result; then SRL amt=0 -> q unchanged, done one cycle, busy never high.
REQ-033 Reset mid-operation: assert rst at 2nd edge of ROL amt=6 -> next cycle q=0, busy=0, done=0, and no later done pulse.
REQ-034 Back-to-back: start ROR amt=1 on the cycle done is high from a prior LOAD 8'h01 -> q=8'h80, done high two consecutive cycles.

Source files
------------

// File: rtl/multi_mode_shift_reg.sv
// multi_mode_shift_reg: load/shift/rotate register stepping one bit per clock for multi-bit distances
module multi_mode_shift_reg #(
    parameter int N     = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [N-1:0]     d,
    input  logic             sin,
    output logic [N-1:0]     q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {NOP, LOAD, SLL, SRL, ROL, ROR, SRA, SLA} mode_t;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    mode_t            r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic [N-1:0]     r_q;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    mode_t            w_mode;
    logic             w_left;
    logic             w_fill;
    logic             w_out;
    logic [N-1:0]     w_next;
    assign q    = r_q;
    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;
    // the accept edge steps with the incoming mode, later edges with the latched one
    always_comb begin
        w_mode = (r_state == IDLE) ? mode_t'(mode) : r_mode;
        w_left = (w_mode == SLL) || (w_mode == ROL) || (w_mode == SLA);
        w_fill = (w_mode == SLL || w_mode == SRL) ? sin :
                 (w_mode == ROL || w_mode == SRA) ? r_q[N-1] :
                 (w_mode == ROR) ? r_q[0] : 1'b0;
        w_next = w_left ? {r_q[N-2:0], w_fill} : {w_fill, r_q[N-1:1]};
        w_out  = w_left ? r_q[N-1] : r_q[0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= NOP;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == SHIFT) begin
                r_q    <= w_next;
                r_sout <= w_out;
                r_cnt  <= r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else if (start) begin
                if (mode_t'(mode) == LOAD)
                    r_q <= d;
                if (mode_t'(mode) >= SLL && amt != '0) begin
                    r_q    <= w_next;
                    r_sout <= w_out;
                    r_mode <= w_mode;
                    r_cnt  <= amt - AMT_W'(1);
                    if (amt == AMT_W'(1))
                        r_done <= 1'b1;
                    else begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end else
                    r_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multi_mode_shift_reg.sv
// tb_multi_mode_shift_reg: directed and randomized operations checked against an arithmetic reference model
module tb_multi_mode_shift_reg;
    localparam logic [2:0] M_NOP = 3'd0, M_LOAD = 3'd1, M_SLL = 3'd2, M_SRL = 3'd3,
                           M_ROL = 3'd4, M_ROR = 3'd5, M_SRA = 3'd6, M_SLA = 3'd7;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [2:0] amt = '0;
    logic [7:0] d = '0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q = '0;
    logic       exp_sout = 1'b0;

    multi_mode_shift_reg #(.N(8), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
        .d(d), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // whole-operation result: {sout, q} after shifting v by k positions in one go
    function automatic logic [8:0] ref_op(input logic [2:0] m, input int k, input logic [7:0] v,
                                          input logic [7:0] dv, input logic s, input logic so);
        int  vi;
        int  r;
        logic o;
        vi = int'(v);
        if (m == M_NOP) return {so, v};
        if (m == M_LOAD) return {so, dv};
        if (k == 0) return {so, v};
        o = (m == M_SLL || m == M_ROL || m == M_SLA) ? v[8-k] : v[k-1];
        case (m)
            M_SLL:   r = (vi << k) | (s ? (1 << k) - 1 : 0);
            M_SRL:   r = (vi >> k) | (s ? (255 << (8 - k)) : 0);
            M_ROL:   r = (vi << k) | (vi >> (8 - k));
            M_ROR:   r = (vi >> k) | (vi << (8 - k));
            M_SRA:   r = (vi >> k) | (v[7] ? (255 << (8 - k)) : 0);
            default: r = vi << k;
        endcase
        return {o, r[7:0]};
    endfunction

    // junk: 0 = quiet while busy, 1 = random ignored starts, 2 = LOAD 8'h3C held while busy
    task automatic do_op(input logic [2:0] m, input int k, input logic [7:0] dv, input logic s,
                         input int junk, input bit idle_after);
        logic [8:0] r;
        int edges;
        int busy_cnt;
        int early_done;
        r = ref_op(m, k, exp_q, dv, s, exp_sout);
        edges = (m >= M_SLL && k > 0) ? k : 1;
        busy_cnt = 0;
        early_done = 0;
        start = 1'b1; mode = m; amt = 3'(k); d = dv; sin = s;
        for (int e = 1; e <= edges; e++) begin
            @(posedge clk); #1;
            if (e < edges) begin
                busy_cnt += int'(busy);
                early_done += int'(done);
                if (junk == 1) begin
                    start = 1'($urandom_range(0, 1)); mode = 3'($urandom); amt = 3'($urandom); d = 8'($urandom);
                end else if (junk == 2) begin
                    start = 1'b1; mode = M_LOAD; d = 8'h3C;
                end else
                    start = 1'b0;
            end else
                start = 1'b0;
        end
        exp_q = r[7:0];
        exp_sout = r[8];
        chk("q", 32'(q), 32'(exp_q));
        chk("sout", 32'(sout), 32'(exp_sout));
        chk("done", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("busy_cycles", 32'(busy_cnt), 32'(edges - 1));
        chk("early_done", 32'(early_done), 32'd0);
        if (idle_after) begin
            @(posedge clk); #1;
            chk("done_drop", 32'(done), 32'd0);
            chk("idle_q", 32'(q), 32'(exp_q));
        end
    endtask

    initial begin
        int dseen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        do_op(M_LOAD, 0, 8'hA5, 1'b0, 0, 0);
        do_op(M_ROL, 3, 8'h00, 1'b0, 0, 1);
        chk("rol3_val", 32'(q), 32'h2D);
        do_op(M_LOAD, 0, 8'h90, 1'b0, 0, 0);
        do_op(M_SRA, 2, 8'h00, 1'b0, 0, 1);
        chk("sra2_val", 32'(q), 32'hE4);
        do_op(M_LOAD, 0, 8'h81, 1'b0, 0, 0);
        do_op(M_SLA, 1, 8'h00, 1'b0, 0, 1);
        chk("sla1_val", 32'(q), 32'h02);
        do_op(M_LOAD, 0, 8'h0F, 1'b0, 0, 0);
        do_op(M_SLL, 4, 8'h00, 1'b1, 0, 0);
        chk("sll4_val", 32'(q), 32'hFF);
        do_op(M_SRL, 7, 8'h00, 1'b0, 0, 1);
        chk("srl7_val", 32'(q), 32'h01);
        do_op(M_LOAD, 0, 8'hB6, 1'b0, 0, 0);
        do_op(M_ROR, 5, 8'h00, 1'b0, 2, 0);
        chk("ror5_val", 32'(q), 32'hB5);
        do_op(M_SRL, 0, 8'h00, 1'b1, 0, 1);
        do_op(M_LOAD, 0, 8'h01, 1'b0, 0, 0);
        do_op(M_ROR, 1, 8'h00, 1'b0, 0, 1);
        chk("b2b_val", 32'(q), 32'h80);
        do_op(M_LOAD, 0, 8'h5A, 1'b0, 0, 0);
        start = 1'b1; mode = M_ROL; amt = 3'd6;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sout", 32'(sout), 32'd0);
        dseen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            dseen += int'(done) + int'(busy);
        end
        chk("no_late_done", 32'(dseen), 32'd0);
        exp_q = '0;
        exp_sout = 1'b0;
        for (int i = 0; i < 200; i++)
            do_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
